// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG sequencer for the gate1 tessent data mux: TDR plus hold handshake, arm and drain FSM.
// Optional TDR parity protection is enabled by defining FIREBIRD7_DMUX_CTRL_PARITY_EN.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
    parameter int DATA_WIDTH   = 19,
    parameter int ACK_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic                  func_hold_ack,
    output logic                  func_hold_req,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_out,
    output logic                  timeout_err
);

`ifdef FIREBIRD7_DMUX_CTRL_PARITY_EN
    localparam int W = DATA_WIDTH + 3;
`else
    localparam int W = DATA_WIDTH + 2;
`endif
    localparam int CNT_MAX = (ACK_TIMEOUT > DRAIN_CYCLES) ? ACK_TIMEOUT : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

    typedef enum logic [1:0] {IDLE, REQ, ARMED, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt, cnt_inc;
    logic [W-1:0]          sr, cap_val;
    logic [DATA_WIDTH-1:0] ur_data;
    logic                  ur_req;
    logic                  upd, upd_ok, timeout_hit, block_req;
    logic                  hold_nxt, select_nxt;

    assign upd      = ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue;
    assign ijtag_so = sr[0];
    assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

`ifdef FIREBIRD7_DMUX_CTRL_PARITY_EN
    logic parity_err;

    // Total TDR parity must be odd; a bad image leaves UR untouched.
    assign upd_ok    = upd && (^sr);
    assign block_req = timeout_err || parity_err;
    assign cap_val   = {parity_err, ur_data, timeout_err, state == ARMED};

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset)
            parity_err <= 1'b0;
        else if (upd && !(^sr))
            parity_err <= 1'b1;
        else if (upd_ok && sr[1])
            parity_err <= 1'b0;
    end
`else
    assign upd_ok    = upd;
    assign block_req = timeout_err;
    assign cap_val   = {ur_data, timeout_err, state == ARMED};
`endif

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            sr <= '0;
        end else if (ijtag_sel) begin
            if (ijtag_ce)
                sr <= cap_val;
            else if (ijtag_se)
                sr <= {ijtag_si, sr[W-1:1]};
        end
    end

    // clr_err (sr[1]) acts only as a pulse and is never held in UR.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            ur_data <= '0;
            ur_req  <= 1'b0;
        end else if (upd_ok) begin
            ur_data <= sr[DATA_WIDTH+1:2];
            ur_req  <= sr[0];
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset)
            timeout_err <= 1'b0;
        else if (timeout_hit)
            timeout_err <= 1'b1;
        else if (upd_ok && sr[1])
            timeout_err <= 1'b0;
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            func_hold_req  <= 1'b0;
            ijtag_select   <= 1'b0;
            ijtag_data_out <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            func_hold_req  <= hold_nxt;
            ijtag_select   <= select_nxt;
            ijtag_data_out <= ur_data;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (ur_req && !block_req) begin
                    state_nxt = REQ;
                    cnt_nxt   = '0;
                end
            end
            REQ: begin
                // Abort outranks a simultaneous ack.
                if (!ur_req) begin
                    state_nxt = IDLE;
                end else if (func_hold_ack) begin
                    state_nxt = ARMED;
                end else if (cnt == ACK_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ARMED: begin
                if (!ur_req) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt_inc;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave flops aligned with it.
    always_comb begin
        hold_nxt   = (state_nxt != IDLE);
        select_nxt = (state_nxt == ARMED);
    end

endmodule
